kbd_event_ctrl: RTL and testbench
=================================

# kbd_event_ctrl

Sequencer and event buffer for the PS/2 keyboard path. Drains the `ps2_keyboard` receive FIFO with its one-cycle `nextdata_n` handshake and recovers from its overflow. Decodes the raw scancode stream (E0/F0/E1 prefixes) into whole key events and queues them in a small FIFO, which the CPU MMIO port or a UI consumer pops. It replaces ad-hoc per-consumer byte decoding.

## Interface

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of two, at least 2.
- SUPPRESS_REPEAT, 1: when 1, drop typematic repeats of a held make code.

Ports:
- clk  in  1  system clock.
- clrn  in  1  reset; asynchronous, active-low.
- en  in  1  enable; 0 = stop draining ps2_keyboard.
- ps2_data  in  8  head byte of ps2_keyboard.
- ps2_ready  in  1  ps2_keyboard FIFO non-empty.
- ps2_overflow  in  1  ps2_keyboard FIFO overflowed.
- ps2_nextdata_n  out  1  active-low pop strobe to ps2_keyboard.
- ps2_clr  out  1  one-cycle reset pulse to ps2_keyboard.
- evt_valid  out  1  event FIFO non-empty.
- evt_data  out  16  head event: {5'b0, pause, ext, brk, code[7:0]}; 0 when empty.
- evt_pop  in  1  consume head event; ignored when empty.
- evt_count  out  $clog2(FIFO_DEPTH)+1  number of queued events.
- evt_lost  out  1  sticky: an event was dropped because the FIFO was full.
- evt_lost_clr  in  1  clears evt_lost.

## Operation

- Reset values: ps2_nextdata_n=1, ps2_clr=0, evt_valid=0, evt_data=0, evt_count=0, evt_lost=0. The FSM resets to IDLE; the ext, brk and last_make registers and the skip counter reset to 0.
- FSM states: IDLE and ACK.
  - In IDLE with en=1, ps2_ready=1 and ps2_overflow=0: decode ps2_data, register ps2_nextdata_n<=0, go to ACK.
  - ACK lasts exactly one cycle; ps2_nextdata_n<=1, then return to IDLE.
- Decode of the consumed byte, in priority order:
  - skip>0: discard the byte and decrement skip.
  - E1: push a pause event {pause=1, code=E1}, set skip=7, clear ext and brk.
  - E0: set ext.
  - F0: set brk.
  - Any other byte: form event {ext, brk, code}, then clear ext and brk.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - A make event whose {ext, code} equals last_make is dropped.
  - A break event matching last_make clears last_make.
  - A pushed make event sets last_make.
- ps2_overflow=1, which has priority over ps2_ready:
  - pulse ps2_clr for one cycle, force IDLE, hold ps2_nextdata_n=1;
  - clear ext, brk and skip;
  - leave the event FIFO untouched.
- en=0:
  - force IDLE, hold ps2_nextdata_n=1, clear ext, brk, skip and last_make;
  - the event FIFO keeps its contents and still serves evt_pop.
- FIFO full on push: drop the new event and set evt_lost.
- FIFO full with push and pop in the same cycle: pop first, push accepted, evt_count unchanged.
- Empty FIFO with pop and push in the same cycle: push accepted, pop ignored.
- evt_lost_clr and a drop in the same cycle: evt_lost stays 1 (set wins).
- Pointers wrap modulo FIFO_DEPTH.

## Timing

- ps2_ready sampled high in IDLE at cycle N:
  - ps2_nextdata_n is low during cycle N+1 only;
  - a resulting event appears on evt_valid/evt_data at cycle N+1.
- Throughput is at most one byte per 2 cycles. ps2_ready is not re-sampled in ACK.
- evt_pop at cycle M: the next head, or evt_valid=0, appears at cycle M+1.
- evt_count updates in the cycle after the push or pop.
- clrn assertion mid-ACK: ps2_nextdata_n returns to 1 asynchronously.

## Structure

- Package `kbd_pkg`:
  - `kbd_evt_t` packed struct {pause, ext, brk, code[7:0]};
  - constants KBD_PFX_EXT=8'hE0, KBD_PFX_BRK=8'hF0, KBD_PFX_PAUSE=8'hE1, KBD_PAUSE_TAIL=7.
- FSM state enum `kbd_ctl_state_e` {IDLE, ACK} lives in the package.
- One sub-module, `kbd_evt_fifo`: synchronous FIFO of `kbd_evt_t` with count, full/empty and pop-before-push semantics.

## Test plan

- Bytes 1C, F0 1C -> events 0x001C then 0x011C; each byte gives exactly one ps2_nextdata_n low cycle.
- Bytes E0 74, E0 F0 74 -> events 0x0274, 0x0374.
- Bytes E1 14 77 E1 F0 14 F0 77 then 1C -> exactly two events: 0x04E1, 0x001C.
- SUPPRESS_REPEAT=1, bytes 1C 1C 1C F0 1C 1C -> events 0x001C, 0x011C, 0x001C.
- Depth 8, nine make codes with no pops -> evt_count=8, evt_lost=1, ninth event absent. Then pop plus a new byte in the same cycle -> evt_count stays 8. Then evt_lost_clr -> evt_lost=0.
- ps2_overflow after E0 -> one ps2_clr pulse; following byte 74 -> event 0x0074 (ext cleared).
- clrn low during ACK -> all outputs at reset values, FIFO empty.

Source files
------------

// File: rtl/kbd_event_ctrl_pkg.sv
// kbd_pkg: shared event type, FSM states and scancode constants for kbd_event_ctrl
package kbd_pkg;
  typedef struct packed {
    logic       pause;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;
  typedef enum logic {IDLE, ACK} kbd_ctl_state_e;
  localparam logic [7:0] KBD_PFX_EXT    = 8'hE0;
  localparam logic [7:0] KBD_PFX_BRK    = 8'hF0;
  localparam logic [7:0] KBD_PFX_PAUSE  = 8'hE1;
  localparam logic [2:0] KBD_PAUSE_TAIL = 3'd7;
  function automatic logic [15:0] kbd_evt_word(kbd_evt_t e);
    return {5'b0, e};
  endfunction
endpackage

// File: rtl/kbd_event_ctrl_if.sv
// kbd_event_ctrl_if: ps2_keyboard drain port plus event FIFO consumer port
// master = kbd_event_ctrl side, slave = keyboard/consumer side
interface kbd_event_ctrl_if #(parameter int FIFO_DEPTH = 8);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [7:0]    ps2_data;
  logic          ps2_ready;
  logic          ps2_overflow;
  logic          ps2_nextdata_n;
  logic          ps2_clr;
  logic          evt_valid;
  logic [15:0]   evt_data;
  logic          evt_pop;
  logic [CW-1:0] evt_count;
  logic          evt_lost;
  logic          evt_lost_clr;
  modport master (
    input  ps2_data, ps2_ready, ps2_overflow, evt_pop, evt_lost_clr,
    output ps2_nextdata_n, ps2_clr, evt_valid, evt_data, evt_count, evt_lost
  );
  modport slave (
    output ps2_data, ps2_ready, ps2_overflow, evt_pop, evt_lost_clr,
    input  ps2_nextdata_n, ps2_clr, evt_valid, evt_data, evt_count, evt_lost
  );
endinterface

// File: rtl/kbd_event_ctrl_fifo.sv
// kbd_evt_fifo: synchronous event FIFO, pop-before-push when full, pop ignored when empty
// ports: i_push/i_data write, i_pop read, o_data head (0 when empty), o_empty, o_drop (push refused), o_count
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       i_push,
  input  kbd_evt_t   i_data,
  input  logic       i_pop,
  output kbd_evt_t   o_data,
  output logic       o_empty,
  output logic       o_drop,
  output logic [AW:0] o_count
);
  kbd_evt_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_full, w_pop, w_push;
  assign o_empty = r_cnt == '0;
  assign w_full  = r_cnt == (AW+1)'(DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  // a pop frees the slot the simultaneous push needs
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & ~w_push;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: drains ps2_keyboard, decodes E0/F0/E1 scancodes into key events, queues them
// ports: clk, clrn (async active-low), en (0 = stop draining), bus (kbd_event_ctrl_if.master)
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter bit SUPPRESS_REPEAT = 1
) (
  input  logic clk,
  input  logic clrn,
  input  logic en,
  kbd_event_ctrl_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  kbd_ctl_state_e r_state, w_state_nx;
  logic r_nd, w_nd_nx, r_clr, r_ext, w_ext_nx, r_brk, w_brk_nx, r_lost;
  logic [2:0] r_skip, w_skip_nx;
  logic [8:0] r_last, w_last_nx, w_key;
  logic w_push, w_drop, w_empty;
  kbd_evt_t w_evt, w_head;
  logic [CW-1:0] w_count;
  assign w_key = {r_ext, bus.ps2_data};
  always_comb begin
    w_state_nx = IDLE;
    w_nd_nx    = 1'b1;
    w_ext_nx   = r_ext;
    w_brk_nx   = r_brk;
    w_skip_nx  = r_skip;
    w_last_nx  = r_last;
    w_push     = 1'b0;
    w_evt      = '{1'b0, r_ext, r_brk, bus.ps2_data};
    if (!en) begin
      w_ext_nx  = 1'b0;
      w_brk_nx  = 1'b0;
      w_skip_nx = '0;
      w_last_nx = '0;
    end else if (bus.ps2_overflow) begin
      w_ext_nx  = 1'b0;
      w_brk_nx  = 1'b0;
      w_skip_nx = '0;
    end else if (r_state == IDLE && bus.ps2_ready) begin
      w_state_nx = ACK;
      w_nd_nx    = 1'b0;
      if (r_skip != '0) w_skip_nx = r_skip - 3'd1;
      else if (bus.ps2_data == KBD_PFX_PAUSE) begin
        w_push    = 1'b1;
        w_evt     = '{1'b1, 1'b0, 1'b0, KBD_PFX_PAUSE};
        w_skip_nx = KBD_PAUSE_TAIL;
        w_ext_nx  = 1'b0;
        w_brk_nx  = 1'b0;
      end else if (bus.ps2_data == KBD_PFX_EXT) w_ext_nx = 1'b1;
      else if (bus.ps2_data == KBD_PFX_BRK) w_brk_nx = 1'b1;
      else begin
        w_ext_nx = 1'b0;
        w_brk_nx = 1'b0;
        if (!SUPPRESS_REPEAT) w_push = 1'b1;
        else if (r_brk) begin
          w_push = 1'b1;
          if (w_key == r_last) w_last_nx = '0;
        end else if (w_key != r_last) begin
          w_push    = 1'b1;
          w_last_nx = w_key;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      r_state <= IDLE;
      r_nd    <= 1'b1;
      r_clr   <= 1'b0;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_skip  <= '0;
      r_last  <= '0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_nd    <= w_nd_nx;
      // keeps the clear a single-cycle pulse even if overflow lingers
      r_clr   <= bus.ps2_overflow & ~r_clr;
      r_ext   <= w_ext_nx;
      r_brk   <= w_brk_nx;
      r_skip  <= w_skip_nx;
      r_last  <= w_last_nx;
      r_lost  <= w_drop | (r_lost & ~bus.evt_lost_clr);
    end
  kbd_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .clrn   (clrn),
    .i_push (w_push),
    .i_data (w_evt),
    .i_pop  (bus.evt_pop),
    .o_data (w_head),
    .o_empty(w_empty),
    .o_drop (w_drop),
    .o_count(w_count)
  );
  assign bus.ps2_nextdata_n = r_nd;
  assign bus.ps2_clr        = r_clr;
  assign bus.evt_valid      = ~w_empty;
  assign bus.evt_data       = kbd_evt_word(w_head);
  assign bus.evt_count      = w_count;
  assign bus.evt_lost       = r_lost;
endmodule

// File: tb/tb_kbd_event_ctrl.sv
// tb_kbd_event_ctrl: directed scoreboard bench for kbd_event_ctrl
module tb_kbd_event_ctrl;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic en = 1'b0;
  int checks = 0;
  int failures = 0;
  int nd_lows = 0;
  int clr_pulses = 0;
  int sent = 0;
  logic [15:0] exp_q [$];
  kbd_event_ctrl_if #(.FIFO_DEPTH(8)) bus ();
  kbd_event_ctrl #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1'b1)) dut (
    .clk (clk),
    .clrn(clrn),
    .en  (en),
    .bus (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.ps2_nextdata_n === 1'b0) nd_lows++;
    if (bus.ps2_clr === 1'b1) clr_pulses++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.ps2_data = b;
    bus.ps2_ready = 1'b1;
    sent++;
    @(negedge clk);
    bus.ps2_ready = 1'b0;
    chk("nd_low", 32'(bus.ps2_nextdata_n), 0);
    @(negedge clk);
    chk("nd_high", 32'(bus.ps2_nextdata_n), 1);
  endtask
  task automatic drain(input string tag);
    logic [31:0] e;
    @(negedge clk);
    for (int i = 0; i < 20 && bus.evt_valid === 1'b1; i++) begin
      e = 32'hDEAD;
      if (exp_q.size() != 0) e = 32'(exp_q.pop_front());
      chk(tag, 32'(bus.evt_data), e);
      bus.evt_pop = 1'b1;
      @(negedge clk);
      bus.evt_pop = 1'b0;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_valid"}, 32'(bus.evt_valid), 0);
    chk({tag, "_nd_lows"}, nd_lows, sent);
  endtask
  initial begin
    bus.ps2_data = '0;
    bus.ps2_ready = 1'b0;
    bus.ps2_overflow = 1'b0;
    bus.evt_pop = 1'b0;
    bus.evt_lost_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_nd", 32'(bus.ps2_nextdata_n), 1);
    chk("rst_clr", 32'(bus.ps2_clr), 0);
    chk("rst_valid", 32'(bus.evt_valid), 0);
    chk("rst_data", 32'(bus.evt_data), 0);
    chk("rst_count", 32'(bus.evt_count), 0);
    chk("rst_lost", 32'(bus.evt_lost), 0);
    clrn = 1'b1;
    en = 1'b1;
    send(8'h1C); exp_q.push_back(16'h001C);
    send(8'hF0); send(8'h1C); exp_q.push_back(16'h011C);
    drain("make_break");
    send(8'hE0); send(8'h74); exp_q.push_back(16'h0274);
    send(8'hE0); send(8'hF0); send(8'h74); exp_q.push_back(16'h0374);
    drain("ext");
    send(8'hE1); exp_q.push_back(16'h04E1);
    send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C); exp_q.push_back(16'h001C);
    drain("pause");
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
    send(8'h1C); exp_q.push_back(16'h001C);
    send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); exp_q.push_back(16'h011C);
    send(8'h1C); exp_q.push_back(16'h001C);
    drain("repeat");
    for (int i = 0; i < 9; i++) begin
      send(8'(8'h10 + i));
      if (i < 8) exp_q.push_back(16'(16'h0010 + i));
    end
    chk("full_count", 32'(bus.evt_count), 8);
    chk("full_lost", 32'(bus.evt_lost), 1);
    chk("full_valid", 32'(bus.evt_valid), 1);
    bus.ps2_data = 8'h19;
    bus.ps2_ready = 1'b1;
    bus.evt_pop = 1'b1;
    sent++;
    chk("full_head", 32'(bus.evt_data), 32'(exp_q.pop_front()));
    exp_q.push_back(16'h0019);
    @(negedge clk);
    bus.ps2_ready = 1'b0;
    bus.evt_pop = 1'b0;
    chk("poppush_count", 32'(bus.evt_count), 8);
    chk("poppush_lost", 32'(bus.evt_lost), 1);
    chk("popush_nd", 32'(bus.ps2_nextdata_n), 0);
    @(negedge clk);
    bus.evt_lost_clr = 1'b1;
    @(negedge clk);
    bus.evt_lost_clr = 1'b0;
    chk("lost_clr", 32'(bus.evt_lost), 0);
    drain("full");
    send(8'hE0);
    bus.ps2_overflow = 1'b1;
    @(negedge clk);
    bus.ps2_overflow = 1'b0;
    chk("ovf_clr_hi", 32'(bus.ps2_clr), 1);
    @(negedge clk);
    chk("ovf_clr_lo", 32'(bus.ps2_clr), 0);
    send(8'h74); exp_q.push_back(16'h0074);
    drain("ovf");
    chk("clr_pulses", clr_pulses, 1);
    @(negedge clk);
    bus.ps2_data = 8'h2A;
    bus.ps2_ready = 1'b1;
    @(negedge clk);
    chk("ack_nd", 32'(bus.ps2_nextdata_n), 0);
    chk("ack_valid", 32'(bus.evt_valid), 1);
    chk("ack_data", 32'(bus.evt_data), 32'h002A);
    #2 clrn = 1'b0;
    bus.ps2_ready = 1'b0;
    #1;
    chk("arst_nd", 32'(bus.ps2_nextdata_n), 1);
    chk("arst_valid", 32'(bus.evt_valid), 0);
    chk("arst_data", 32'(bus.evt_data), 0);
    chk("arst_count", 32'(bus.evt_count), 0);
    chk("arst_lost", 32'(bus.evt_lost), 0);
    chk("arst_clr", 32'(bus.ps2_clr), 0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.evt_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
